// File: rtl/axi_bridge_mp_pkg.sv
// ---------------------------------------------------------------------------
// axi_bridge_pkg
// Shared definitions for the multi-port SRAM-like to AXI3 bridge:
//   - constant AXI field encodings (single-beat INCR, OKAY response)
//   - write engine state encoding
//   - port-index-to-AXI-ID mapping
//   - word-granular address compare used by the read-after-write check
// ---------------------------------------------------------------------------
package axi_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'h00;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        WR_IDLE,   // no write in flight
        WR_SEND,   // AW and/or W still waiting for their handshake
        WR_RESP    // both sent, waiting for B
    } wr_state_e;

    // The AXI ID of a transaction is simply the issuing port index; the
    // caller truncates to its ID width.
    function automatic logic [31:0] port_to_id(input int unsigned port);
        return 32'(port);
    endfunction

    // True when both byte addresses fall in the same data-bus word.
    function automatic logic word_addr_eq(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned lsb);
        return (a >> lsb) == (b >> lsb);
    endfunction

endpackage

// File: rtl/axi_bridge_mp_if.sv
// ---------------------------------------------------------------------------
// axi_bridge_mp_if
// AXI3 bus bundle between the bridge and the SoC crossbar.
//   AR: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
//       arvalid, arready
//   R : rid, rdata, rresp, rlast, rvalid, rready
//   AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
//       awvalid, awready
//   W : wid, wdata, wstrb, wlast, wvalid, wready
//   B : bid, bresp, bvalid, bready
// Modports: master (bridge side), slave (interconnect / memory model side).
// ---------------------------------------------------------------------------
interface axi_bridge_mp_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     arid;
    logic [31:0]             araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [1:0]              arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    logic [ID_WIDTH-1:0]     awid;
    logic [31:0]             awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [1:0]              awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_bridge_mp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over N requesters. The search starts at the pointer;
// requesters that are not asserting are skipped. When i_adv is high and a
// grant is made, the pointer moves to the granted index + 1 (mod N).
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset (pointer -> 0)
//   i_req         : request vector (already qualified by eligibility)
//   i_adv         : commit the current grant and move the pointer
//   o_grant       : one-hot grant (combinational), zero when no request
//   o_ptr         : current round-robin pointer
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [N-1:0]  i_req,
    input  logic          i_adv,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_gidx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_gidx         = w_idx;
                w_found        = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_ptr <= '0;
        end else if (i_adv && w_found) begin
            r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/axi_bridge_mp.sv
// ---------------------------------------------------------------------------
// axi_bridge_mp
// Connects NUM_PORTS SRAM-like masters (req / addr_ok / data_ok) to a single
// AXI3 master port. Reads may be outstanding (up to MAX_RD_OUT per port) and
// are routed back by ID = port index. One write is in flight at a time; AW
// and W are launched together. Reads to the word of the in-flight write are
// held back until its B response.
// Ports:
//   aclk, aresetn  : clock, synchronous active-low reset
//   i_s_req/i_s_wr : per-port request / write flag
//   i_s_size       : per-port log2(bytes), 3 bits each
//   i_s_addr       : per-port byte address, 32 bits each
//   i_s_wstrb      : per-port write strobes, DATA_WIDTH/8 bits each
//   i_s_wdata      : per-port write data, DATA_WIDTH bits each
//   o_s_addr_ok    : per-port request accept (combinational, grant cycle)
//   o_s_data_ok    : per-port response pulse (read or write)
//   o_s_rdata      : shared read data, valid with a read data_ok
//   m_axi          : AXI3 master bus
//   o_err          : sticky protocol/response error flag
// ---------------------------------------------------------------------------
module axi_bridge_mp
    import axi_bridge_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RD_OUT = 4
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_PORTS-1:0]              i_s_req,
    input  logic [NUM_PORTS-1:0]              i_s_wr,
    input  logic [3*NUM_PORTS-1:0]            i_s_size,
    input  logic [32*NUM_PORTS-1:0]           i_s_addr,
    input  logic [(DATA_WIDTH/8)*NUM_PORTS-1:0] i_s_wstrb,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0]   i_s_wdata,
    output logic [NUM_PORTS-1:0]              o_s_addr_ok,
    output logic [NUM_PORTS-1:0]              o_s_data_ok,
    output logic [DATA_WIDTH-1:0]             o_s_rdata,
    axi_bridge_mp_if.master                   m_axi,
    output logic                              o_err
);

    localparam int SW   = DATA_WIDTH / 8;
    localparam int WLSB = $clog2(SW);
    localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW   = $clog2(MAX_RD_OUT + 1);

    if (ID_WIDTH < PW || MAX_RD_OUT < 1) begin : g_param_chk
        $error("axi_bridge_mp: ID_WIDTH too narrow for NUM_PORTS or MAX_RD_OUT < 1");
    end

    // Arbitration / eligibility
    logic [NUM_PORTS-1:0] w_rd_elig;
    logic [NUM_PORTS-1:0] w_wr_elig;
    logic [NUM_PORTS-1:0] w_req_elig;
    logic [NUM_PORTS-1:0] w_grant;
    logic [NUM_PORTS-1:0] w_rd_inc;
    logic [NUM_PORTS-1:0] w_rd_dec;
    logic [PW-1:0]        w_gidx;
    logic [PW-1:0]        w_rr_ptr;
    logic                 w_ar_free;
    logic                 w_rd_grant;
    logic                 w_wr_grant;
    logic                 w_wr_busy;
    logic                 w_rid_ok;
    logic                 w_b_hs;
    logic                 w_aw_pend_n;
    logic                 w_w_pend_n;

    // Per-port outstanding read counters
    logic [CW-1:0]        r_rd_cnt [NUM_PORTS];

    // AR holding register
    logic                 r_arvalid;
    logic [31:0]          r_araddr;
    logic [2:0]           r_arsize;
    logic [ID_WIDTH-1:0]  r_arid;

    // Write engine
    wr_state_e            r_wst;
    logic                 r_awvalid;
    logic                 r_wvalid;
    logic                 r_bready;
    logic [31:0]          r_awaddr;
    logic [2:0]           r_awsize;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SW-1:0]        r_wstrb;
    logic [ID_WIDTH-1:0]  r_wid;
    logic [PW-1:0]        r_wport;

    logic                 r_err;

    // The AR slot can take a new read if empty or draining this very cycle.
    assign w_ar_free = !r_arvalid || m_axi.arready;
    assign w_wr_busy = (r_wst != WR_IDLE);

    always_comb begin
        w_rd_elig = '0;
        w_wr_elig = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            // r_awaddr stays loaded until the next write grant, so it still
            // names the in-flight write after AW has completed.
            w_rd_elig[p] = w_ar_free
                        && (r_rd_cnt[p] < CW'(MAX_RD_OUT))
                        && !(w_wr_busy && word_addr_eq(i_s_addr[32*p +: 32], r_awaddr, WLSB));
            w_wr_elig[p] = !w_wr_busy;
        end
        w_req_elig = i_s_req & ((~i_s_wr & w_rd_elig) | (i_s_wr & w_wr_elig));
    end

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_req   (w_req_elig),
        .i_adv   (|w_req_elig),
        .o_grant (w_grant),
        .o_ptr   (w_rr_ptr)
    );

    always_comb begin
        w_gidx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_grant[p]) w_gidx = PW'(p);
        end
    end

    assign w_rd_inc    = w_grant & ~i_s_wr;
    assign w_rd_grant  = |w_rd_inc;
    assign w_wr_grant  = |(w_grant & i_s_wr);
    assign o_s_addr_ok = w_grant;

    // Responses: read routed by rid, write by the stored port (bid ignored).
    assign w_rid_ok = (32'(m_axi.rid) < 32'(NUM_PORTS));
    assign w_b_hs   = m_axi.bvalid && r_bready;

    always_comb begin
        w_rd_dec = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_rd_dec[p] = m_axi.rvalid && w_rid_ok && (32'(m_axi.rid) == 32'(p));
        end
        o_s_data_ok = w_rd_dec;
        if (w_b_hs) o_s_data_ok[r_wport] = 1'b1;
    end

    assign o_s_rdata = m_axi.rdata;

    always_ff @(posedge aclk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!aresetn) begin
                r_rd_cnt[p] <= '0;
            end else if (w_rd_inc[p] && !w_rd_dec[p]) begin
                r_rd_cnt[p] <= r_rd_cnt[p] + CW'(1);
            end else if (!w_rd_inc[p] && w_rd_dec[p] && r_rd_cnt[p] != '0) begin
                r_rd_cnt[p] <= r_rd_cnt[p] - CW'(1);
            end
        end
    end

    // AR channel
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_arvalid <= 1'b0;
        end else if (w_rd_grant) begin
            r_arvalid <= 1'b1;
        end else if (m_axi.arready) begin
            r_arvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_rd_grant) begin
            r_araddr <= i_s_addr[32*w_gidx +: 32];
            r_arsize <= i_s_size[3*w_gidx +: 3];
            r_arid   <= ID_WIDTH'(port_to_id(32'(w_gidx)));
        end
    end

    // Write engine: AW and W drop independently; B is accepted only after both.
    assign w_aw_pend_n = r_awvalid && !m_axi.awready;
    assign w_w_pend_n  = r_wvalid  && !m_axi.wready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wst     <= WR_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_wst)
                WR_IDLE: begin
                    if (w_wr_grant) begin
                        r_wst     <= WR_SEND;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                WR_SEND: begin
                    if (m_axi.awready) r_awvalid <= 1'b0;
                    if (m_axi.wready)  r_wvalid  <= 1'b0;
                    if (!w_aw_pend_n && !w_w_pend_n) begin
                        r_wst    <= WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        r_wst    <= WR_IDLE;
                        r_bready <= 1'b0;
                    end
                end
                default: begin
                    r_wst     <= WR_IDLE;
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_wr_grant) begin
            r_awaddr <= i_s_addr[32*w_gidx +: 32];
            r_awsize <= i_s_size[3*w_gidx +: 3];
            r_wdata  <= i_s_wdata[DATA_WIDTH*w_gidx +: DATA_WIDTH];
            r_wstrb  <= i_s_wstrb[SW*w_gidx +: SW];
            r_wid    <= ID_WIDTH'(port_to_id(32'(w_gidx)));
            r_wport  <= w_gidx;
        end
    end

    // Sticky error: unknown rid (beat dropped), error responses, unsolicited B.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_err <= 1'b0;
        end else if ((m_axi.rvalid && (!w_rid_ok || m_axi.rresp != RESP_OKAY))
                  || (m_axi.bvalid && (!r_bready || m_axi.bresp != RESP_OKAY))) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;

    assign m_axi.arid    = r_arid;
    assign m_axi.araddr  = r_araddr;
    assign m_axi.arlen   = LEN_SINGLE;
    assign m_axi.arsize  = r_arsize;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arlock  = '0;
    assign m_axi.arcache = '0;
    assign m_axi.arprot  = '0;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = 1'b1;

    assign m_axi.awid    = r_wid;
    assign m_axi.awaddr  = r_awaddr;
    assign m_axi.awlen   = LEN_SINGLE;
    assign m_axi.awsize  = r_awsize;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awlock  = '0;
    assign m_axi.awcache = '0;
    assign m_axi.awprot  = '0;
    assign m_axi.awvalid = r_awvalid;

    assign m_axi.wid     = r_wid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;

    // Single-beat bursts make rlast redundant; B is routed by stored port.
    logic w_unused;
    assign w_unused = ^{m_axi.rlast, m_axi.bid, w_rr_ptr};

endmodule

// File: tb/tb_axi_bridge_mp.sv
// ---------------------------------------------------------------------------
// tb_axi_bridge_mp
// Directed bench for axi_bridge_mp with NUM_PORTS=2, DATA_WIDTH=32,
// MAX_RD_OUT=4. The bench plays the AXI slave side by hand.
// ---------------------------------------------------------------------------
module tb_axi_bridge_mp;

    logic        aclk;
    logic        aresetn;
    logic [1:0]  s_req;
    logic [1:0]  s_wr;
    logic [5:0]  s_size;
    logic [63:0] s_addr;
    logic [7:0]  s_wstrb;
    logic [63:0] s_wdata;
    logic [1:0]  s_addr_ok;
    logic [1:0]  s_data_ok;
    logic [31:0] s_rdata;
    logic        err;

    int n_chk = 0;
    int n_bad = 0;

    axi_bridge_mp_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) ax ();

    axi_bridge_mp #(
        .NUM_PORTS  (2),
        .ID_WIDTH   (4),
        .DATA_WIDTH (32),
        .MAX_RD_OUT (4)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_s_req     (s_req),
        .i_s_wr      (s_wr),
        .i_s_size    (s_size),
        .i_s_addr    (s_addr),
        .i_s_wstrb   (s_wstrb),
        .i_s_wdata   (s_wdata),
        .o_s_addr_ok (s_addr_ok),
        .o_s_data_ok (s_data_ok),
        .o_s_rdata   (s_rdata),
        .m_axi       (ax),
        .o_err       (err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clr_req();
        s_req = '0;
        s_wr  = '0;
    endtask

    task automatic set_rd(input int p, input logic [31:0] a);
        s_req[p]           = 1'b1;
        s_wr[p]            = 1'b0;
        s_addr[32*p +: 32] = a;
        s_size[3*p +: 3]   = 3'd2;
    endtask

    task automatic set_wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        s_req[p]            = 1'b1;
        s_wr[p]             = 1'b1;
        s_addr[32*p +: 32]  = a;
        s_size[3*p +: 3]    = 3'd2;
        s_wdata[32*p +: 32] = d;
        s_wstrb[4*p +: 4]   = st;
    endtask

    task automatic do_reset();
        aresetn    = 1'b0;
        clr_req();
        ax.arready = 1'b0;
        ax.rvalid  = 1'b0;
        ax.rid     = '0;
        ax.rresp   = 2'b00;
        ax.awready = 1'b0;
        ax.wready  = 1'b0;
        ax.bvalid  = 1'b0;
        ax.bresp   = 2'b00;
        repeat (3) step();
        aresetn = 1'b1;
    endtask

    initial begin
        s_size     = '0;
        s_addr     = '0;
        s_wstrb    = '0;
        s_wdata    = '0;
        ax.rdata   = '0;
        ax.rlast   = 1'b1;
        ax.bid     = '0;
        aresetn    = 1'b0;

        // ---------------- reset values ----------------
        aresetn = 1'b0;
        clr_req();
        ax.arready = 1'b0; ax.rvalid = 1'b0; ax.rid = '0; ax.rresp = '0;
        ax.awready = 1'b0; ax.wready = 1'b0; ax.bvalid = 1'b0; ax.bresp = '0;
        repeat (3) step();
        chk("rst_arvalid", ax.arvalid, 0);
        chk("rst_awvalid", ax.awvalid, 0);
        chk("rst_wvalid",  ax.wvalid,  0);
        chk("rst_bready",  ax.bready,  0);
        chk("rst_err",     err,        0);
        chk("rst_addr_ok", s_addr_ok,  0);
        chk("rst_data_ok", s_data_ok,  0);
        chk("rst_rready",  ax.rready,  1);

        // ---------------- single read ----------------
        do_reset();
        set_rd(0, 32'h1C00_0000);
        ax.arready = 1'b1;
        #1 chk("rd1_addr_ok", s_addr_ok, 2'b01);
        step();
        clr_req();
        #1;
        chk("rd1_arvalid", ax.arvalid, 1);
        chk("rd1_araddr",  ax.araddr,  32'h1C00_0000);
        chk("rd1_arid",    ax.arid,    0);
        chk("rd1_arsize",  ax.arsize,  2);
        chk("rd1_arlen",   ax.arlen,   0);
        chk("rd1_arburst", ax.arburst, 2'b01);
        chk("rd1_arprot",  {ax.arlock, ax.arcache, ax.arprot}, 0);
        step();
        #1 chk("rd1_ar_drop", ax.arvalid, 0);
        step();
        ax.rvalid = 1'b1; ax.rid = 4'd0; ax.rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd1_data_ok", s_data_ok, 2'b01);
        chk("rd1_rdata",   s_rdata,   32'hDEAD_BEEF);
        step();
        ax.rvalid = 1'b0;
        #1 chk("rd1_data_ok_end", s_data_ok, 0);

        // ---------------- AR hold while arready low ----------------
        do_reset();
        set_rd(0, 32'h0000_0040);
        #1 chk("arh_ack0", s_addr_ok, 2'b01);
        step();
        set_rd(0, 32'h0000_0044);
        #1;
        chk("arh_valid1", ax.arvalid, 1);
        chk("arh_full",   s_addr_ok,  0);
        step();
        #1;
        chk("arh_valid2", ax.arvalid, 1);
        chk("arh_stable", ax.araddr,  32'h0000_0040);
        ax.arready = 1'b1;
        #1 chk("arh_ack_on_drain", s_addr_ok, 2'b01);
        step();
        clr_req();
        ax.arready = 1'b0;
        #1;
        chk("arh_valid3", ax.arvalid, 1);
        chk("arh_addr3",  ax.araddr,  32'h0000_0044);

        // ---------------- round-robin ----------------
        do_reset();
        set_rd(0, 32'h0000_1000);
        set_rd(1, 32'h0000_2000);
        ax.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_grant%0d", i), s_addr_ok, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) chk($sformatf("rr_arid%0d", i), ax.arid, (i - 1) % 2);
            step();
        end
        clr_req();

        // ---------------- outstanding limit ----------------
        do_reset();
        set_rd(1, 32'h0000_3000);
        ax.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("lim_ack%0d", i), s_addr_ok, 2'b10);
            step();
        end
        #1 chk("lim_5th_blocked", s_addr_ok, 0);
        step();
        #1 chk("lim_5th_still", s_addr_ok, 0);
        step();
        ax.rvalid = 1'b1; ax.rid = 4'd1; ax.rdata = 32'h0000_0055;
        #1;
        chk("lim_rsp_ok",     s_data_ok, 2'b10);
        chk("lim_rsp_cycle",  s_addr_ok, 0);
        step();
        ax.rvalid = 1'b0;
        #1 chk("lim_5th_acked", s_addr_ok, 2'b10);
        step();
        #1 chk("lim_full_again", s_addr_ok, 0);
        clr_req();

        // ---------------- write handshake order + RAW ----------------
        do_reset();
        ax.arready = 1'b1;
        set_wr(1, 32'h0000_0800, 32'h1234_5678, 4'hF);
        #1 chk("wr_addr_ok", s_addr_ok, 2'b10);
        step();
        clr_req();
        ax.wready = 1'b1;
        #1;
        chk("wr_awvalid1", ax.awvalid, 1);
        chk("wr_wvalid1",  ax.wvalid,  1);
        chk("wr_awaddr",   ax.awaddr,  32'h0000_0800);
        chk("wr_wdata",    ax.wdata,   32'h1234_5678);
        chk("wr_wstrb",    ax.wstrb,   4'hF);
        chk("wr_ids",      {ax.awid, ax.wid}, 8'h11);
        chk("wr_wlast",    ax.wlast,   1);
        chk("wr_bready1",  ax.bready,  0);
        step();
        ax.wready = 1'b0;
        #1;
        chk("wr_wvalid2",  ax.wvalid,  0);
        chk("wr_awvalid2", ax.awvalid, 1);
        chk("wr_bready2",  ax.bready,  0);
        step();
        ax.awready = 1'b1;
        #1 chk("wr_bready3", ax.bready, 0);
        step();
        ax.awready = 1'b0;
        set_rd(0, 32'h0000_0802);
        #1;
        chk("wr_awvalid4", ax.awvalid, 0);
        chk("wr_bready4",  ax.bready,  1);
        chk("raw_blocked", s_addr_ok,  0);
        step();
        set_rd(0, 32'h0000_0804);
        #1 chk("raw_other_word", s_addr_ok, 2'b01);
        step();
        set_rd(0, 32'h0000_0802);
        ax.bvalid = 1'b1;
        #1;
        chk("wr_b_data_ok",  s_data_ok, 2'b10);
        chk("raw_blocked_b", s_addr_ok, 0);
        step();
        ax.bvalid = 1'b0;
        #1;
        chk("wr_b_once",     s_data_ok, 0);
        chk("raw_released",  s_addr_ok, 2'b01);
        chk("wr_bready_end", ax.bready, 0);
        chk("wr_err",        err,       0);
        step();
        clr_req();

        // ---------------- errors ----------------
        do_reset();
        ax.arready = 1'b1;
        set_rd(1, 32'h0000_5000);
        repeat (4) step();
        clr_req();
        ax.rvalid = 1'b1; ax.rid = 4'd5; ax.rdata = 32'hBAD0_BAD0;
        #1 chk("err_rid_no_ok", s_data_ok, 0);
        step();
        ax.rvalid = 1'b0;
        set_rd(1, 32'h0000_5000);
        #1;
        chk("err_rid_set",   err,       1);
        chk("err_cnt_kept",  s_addr_ok, 0);
        step();
        clr_req();
        step();
        #1 chk("err_sticky", err, 1);

        do_reset();
        #1 chk("err_cleared", err, 0);
        ax.rvalid = 1'b1; ax.rid = 4'd0; ax.rresp = 2'b10;
        step();
        ax.rvalid = 1'b0; ax.rresp = 2'b00;
        #1 chk("err_rresp", err, 1);

        do_reset();
        ax.bvalid = 1'b1;
        step();
        ax.bvalid = 1'b0;
        #1 chk("err_b_unsolicited", err, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_bridge_mp.md
Name: axi_bridge_mp

Overview:
Parametrised successor to the two-port SRAM-like-to-AXI3 bridge. It connects NUM_PORTS SRAM-like masters (req/addr_ok/data_ok protocol) to one AXI master port. Multiple reads per port may be outstanding, identified by port-indexed IDs. AW and W are issued concurrently. A read-after-write address hazard check is included. It sits between the CPU's inst/data caches and the SoC AXI crossbar.

Parameters:
NUM_PORTS, 2, number of SRAM-like masters; port 0 is inst, port 1 is data.
ID_WIDTH, 4, AXI ID width; must be at least clog2(NUM_PORTS).
DATA_WIDTH, 32, data width (32 or 64); strobe width is DATA_WIDTH/8.
MAX_RD_OUT, 4, maximum outstanding reads per port (at least 1).

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_req/s_wr  in  NUM_PORTS  per-port request / write flag
s_size  in  3*NUM_PORTS  log2 of bytes per port
s_addr  in  32*NUM_PORTS  per-port byte address
s_wstrb  in  (DATA_WIDTH/8)*NUM_PORTS  per-port write strobes
s_wdata  in  DATA_WIDTH*NUM_PORTS  per-port write data
s_addr_ok/s_data_ok  out  NUM_PORTS  per-port accept / response pulse
s_rdata  out  DATA_WIDTH  shared read data, qualified by s_data_ok
AXI AR: arid ID_WIDTH, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid out, arready in
AXI R: rid ID_WIDTH, rdata DATA_WIDTH, rresp 2, rlast 1, rvalid in, rready out
AXI AW/W: awid/wid ID_WIDTH, awaddr 32, awlen/awsize/awburst/awlock/awcache/awprot, awvalid out, awready in, wdata, wstrb, wlast, wvalid out, wready in
AXI B: bid ID_WIDTH, bresp 2, bvalid in, bready out
err  out  1  sticky error flag

Behaviour:
- Reset values: arvalid=awvalid=wvalid=bready=0, err=0, all s_addr_ok/s_data_ok=0, per-port read counters=0, RR pointer=0. rready is constant 1.
- Constant AXI fields: arlen=awlen=0, burst=2'b01, lock=cache=prot=0, wlast=1.
- Arbitration:
  - Exactly one request is granted per cycle, chosen round-robin starting at the RR pointer.
  - Only eligible ports take part; ineligible ports are skipped, never stalled on.
  - The pointer moves to the granted port + 1, wrapping modulo NUM_PORTS.
- s_addr_ok[p] is combinational and asserted in the grant cycle. The request is captured at that clock edge.
- Read eligibility, all of the following:
  - the AR holding register is empty, or arvalid&&arready this cycle;
  - rd_cnt[p] < MAX_RD_OUT;
  - there is no RAW hazard: a write is in flight (accepted, B not yet received) and addr[31:log2(DATA_WIDTH/8)] is equal.
- Read issue:
  - araddr/arsize are registered; arid = p zero-extended; arvalid=1 from the next cycle.
  - arvalid holds with stable fields until arready.
  - AR latency from grant to arvalid is 1 cycle.
- Read response: on rvalid with rid=q<NUM_PORTS, s_data_ok[q]=1 in the same cycle and s_rdata=rdata. rd_cnt[q] decrements.
- Counter update: a simultaneous increment and decrement of one counter leaves it unchanged.
- Write eligibility: the write engine is idle (no write in flight). WAR ordering is not checked; masters do not write an address with a read still pending.
- Write issue:
  - awaddr/awsize/wdata/wstrb are registered; awid=wid=p.
  - awvalid and wvalid both rise on the next cycle.
  - Each drops independently on its own handshake; either order, or both in the same cycle, is legal.
  - bready=1 once both handshakes are done, until bvalid.
- Write response: on bvalid&&bready, s_data_ok[stored port]=1 for one cycle and the engine returns to idle. The stored port is used, not bid.
- Read and write responses in the same cycle: both pulse, on different ports or the same port. s_rdata is meaningful only for the read.
- err is set, and stays set until reset, on any of:
  - rvalid with rid >= NUM_PORTS (the beat is also dropped);
  - rresp != 0 or bresp != 0;
  - bvalid while bready=0.
- Reset mid-transaction: all state clears. Late AXI responses after reset are the interconnect's responsibility; the bridge assumes reset is applied SoC-wide.

Decomposition:
- Package axi_bridge_pkg holds:
  - the AXI constant encodings (BURST_INCR, LEN_SINGLE, RESP_OKAY);
  - the port-index-to-ID function;
  - the word-address compare function.
- One sub-module: rr_arbiter, parametrised on N. Inputs are request vector and advance; outputs are a one-hot grant vector and the pointer.

Test Plan:
- Single read, NUM_PORTS=2: port0 req addr 0x1C000000 size 2; arready=1; rvalid with rid=0, rdata=0xDEADBEEF after 3 cycles -> s_addr_ok[0] in cycle 0, arvalid in cycle 1 with arid=0, s_data_ok[0] with rdata 0xDEADBEEF.
- Outstanding limit, MAX_RD_OUT=4: port1 issues 5 back-to-back reads with R withheld -> 4 addr_oks, 5th req not acked. One rvalid rid=1 -> 5th acked the next grant cycle.
- Round-robin: both ports hold read req continuously, arready=1 -> grants alternate 0,1,0,1. The pointer starts at 0 after reset.
- Write handshake order: port1 write 0x800 data 0x12345678 strb 4'hF; wready at cycle 1, awready at cycle 3 -> bready only after cycle 3. bvalid -> s_data_ok[1] once.
- RAW hazard: port1 write 0x800 in flight and port0 read 0x802 -> read not acked until the cycle after bvalid. A read to 0x804 is acked immediately.
- Error: rvalid with rid=5 -> err=1 and stays 1; no s_data_ok pulses; counters unchanged.
